// File: rtl/caeco_stream_feeder_pkg.sv
// Shared constants for the caeco stream feeder: register map, CMD/STATUS bit positions,
// the PACK half-word width and the saturating level helper.
package caeco_stream_feeder_pkg;

   localparam logic [3:0] ADDR_CMD    = 4'd0;
   localparam logic [3:0] ADDR_STATUS = 4'd1;
   localparam logic [3:0] ADDR_RESULT = 4'd2;
   localparam logic [3:0] ADDR_THRESH = 4'd3;
   localparam logic [3:0] ADDR_DATA0  = 4'd4;

   localparam int CMD_RUN  = 0;
   localparam int CMD_PACK = 1;
   localparam int CMD_EOR  = 3;
   localparam int CMD_ARM  = 4;

   localparam int ST_RES_VALID = 0;
   localparam int ST_OVERFLOW  = 1;
   localparam int ST_DONE      = 2;
   localparam int ST_ALL_EMPTY = 3;
   localparam int ST_ANY_FULL  = 4;

   localparam int PACK_HALF_W = 16;

   // STATUS reports the total level in 8 bits, clipped rather than wrapped.
   function automatic logic [7:0] sat_level(input logic [31:0] lvl);
      return (lvl > 32'd255) ? 8'hFF : lvl[7:0];
   endfunction

endpackage

// File: rtl/caeco_chan_fifo.sv
// Per-channel sample FIFO: push of one or two entries per cycle, single pop,
// synchronous flush, level/full/empty status.
module caeco_chan_fifo #(
   parameter  int SAMPLE_W = 32,
   parameter  int DEPTH    = 16,
   localparam int AW       = $clog2(DEPTH),
   localparam int LVL_W    = AW + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_flush,
   input  logic                i_push,
   input  logic                i_push2,
   input  logic [SAMPLE_W-1:0] i_wdata0,
   input  logic [SAMPLE_W-1:0] i_wdata1,
   input  logic                i_pop,
   output logic [SAMPLE_W-1:0] o_rdata,
   output logic [LVL_W-1:0]    o_level,
   output logic                o_full,
   output logic                o_empty
);

   logic [SAMPLE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [LVL_W-1:0]    r_level;
   logic [AW-1:0]       w_wr_ptr_nxt;
   logic [LVL_W-1:0]    w_push_n;

   assign w_wr_ptr_nxt = r_wr_ptr + AW'(1);
   assign w_push_n     = i_push ? (i_push2 ? LVL_W'(2) : LVL_W'(1)) : '0;

   // NOTE: storage has no reset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_wdata0;
         if (i_push2) r_mem[w_wr_ptr_nxt] <= i_wdata1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + (i_push2 ? AW'(2) : AW'(1));
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + w_push_n - LVL_W'(i_pop);
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_level = r_level;
   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);

endmodule

// File: rtl/caeco_stream_feeder.sv
// Memory-mapped ECG sample ingest: register file, per-channel FIFOs, round-robin
// output slot towards caeco, EOR/DONE tracking and result capture with irq.
module caeco_stream_feeder
   import caeco_stream_feeder_pkg::*;
#(
   parameter  int NUM_CH   = 2,
   parameter  int SAMPLE_W = 32,
   parameter  int DEPTH    = 16,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          reg_addr,
   input  logic                reg_we,
   input  logic                reg_re,
   input  logic [31:0]         reg_wdata,
   output logic [31:0]         reg_rdata,
   output logic                smp_valid,
   input  logic                smp_ready,
   output logic [SAMPLE_W-1:0] smp_data,
   output logic [CH_W-1:0]     smp_ch,
   output logic                smp_last,
   input  logic                res_valid,
   input  logic [31:0]         res_data,
   output logic                irq
);

   localparam bit PACK_OK = (SAMPLE_W <= PACK_HALF_W);

   logic [31:0]         r_cmd, r_thresh, r_result, r_rdata;
   logic                r_res_valid, r_overflow, r_done;
   logic                r_slot_valid, r_slot_last;
   logic [SAMPLE_W-1:0] r_slot_data;
   logic [CH_W-1:0]     r_slot_ch, r_last_grant;

   logic [NUM_CH-1:0]   w_push, w_push2, w_pop, w_empty, w_full;
   logic [LVL_W-1:0]    w_level [NUM_CH];
   logic [SAMPLE_W-1:0] w_head  [NUM_CH];
   logic [SAMPLE_W-1:0] w_wd0, w_wd1;
   logic [3:0]          w_data_idx;
   logic                w_wr_cmd, w_wr_status, w_wr_thresh, w_rd_result, w_data_ok;
   logic                w_pack_mode, w_arm_edge, w_drop, w_any_push, w_all_empty, w_any_full;
   logic [31:0]         w_total_level, w_status;
   logic                w_pick_valid, w_load, w_accept, w_load_last, w_eor_idle, w_done_set;
   logic [CH_W-1:0]     w_pick_ch;

   assign w_wr_cmd    = reg_we && (reg_addr == ADDR_CMD);
   assign w_wr_status = reg_we && (reg_addr == ADDR_STATUS);
   assign w_wr_thresh = reg_we && (reg_addr == ADDR_THRESH);
   assign w_rd_result = reg_re && (reg_addr == ADDR_RESULT);
   assign w_data_idx  = reg_addr - ADDR_DATA0;
   assign w_data_ok   = reg_we && (reg_addr >= ADDR_DATA0) && (int'(w_data_idx) < NUM_CH);
   assign w_pack_mode = PACK_OK && r_cmd[CMD_PACK];
   assign w_arm_edge  = w_wr_cmd && reg_wdata[CMD_ARM] && !r_cmd[CMD_ARM];

   // In PACK mode the upper half-word is the older sample and goes in first.
   assign w_wd0 = w_pack_mode ? SAMPLE_W'(reg_wdata[31:16]) : reg_wdata[SAMPLE_W-1:0];
   assign w_wd1 = SAMPLE_W'(reg_wdata[15:0]);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_push  = '0;
      w_push2 = '0;
      w_drop  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_data_ok && (int'(w_data_idx) == c)) begin
            if (w_pack_mode) begin
               if (int'(w_level[c]) <= DEPTH - 2) begin
                  w_push[c]  = 1'b1;
                  w_push2[c] = 1'b1;
               end else begin
                  w_drop = 1'b1;
               end
            end else if (!w_full[c]) begin
               w_push[c] = 1'b1;
            end else begin
               w_drop = 1'b1;
            end
         end
      end
   end

   assign w_any_push  = |w_push;
   assign w_all_empty = &w_empty;
   assign w_any_full  = |w_full;

   always_comb begin
      w_total_level = '0;
      for (int c = 0; c < NUM_CH; c++) w_total_level = w_total_level + 32'(w_level[c]);
   end

   // Round-robin search begins at the channel after the most recent grant.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_ch    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!w_pick_valid && !w_empty[(int'(r_last_grant) + k) % NUM_CH]) begin
            w_pick_valid = 1'b1;
            w_pick_ch    = CH_W'((int'(r_last_grant) + k) % NUM_CH);
         end
      end
   end

   assign w_accept    = r_slot_valid && smp_ready;
   assign w_load      = r_cmd[CMD_RUN] && (!r_slot_valid || smp_ready) && w_pick_valid;
   assign w_load_last = r_cmd[CMD_EOR] && (w_total_level == 32'd1) && !w_any_push;
   assign w_eor_idle  = r_cmd[CMD_EOR] && w_all_empty && !r_slot_valid;
   assign w_done_set  = (w_accept && r_slot_last) || w_eor_idle;

   always_comb begin
      w_pop = '0;
      if (w_load) w_pop[w_pick_ch] = 1'b1;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      caeco_chan_fifo #(
         .SAMPLE_W (SAMPLE_W),
         .DEPTH    (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .reset    (reset),
         .i_flush  (w_arm_edge),
         .i_push   (w_push[g]),
         .i_push2  (w_push2[g]),
         .i_wdata0 (w_wd0),
         .i_wdata1 (w_wd1),
         .i_pop    (w_pop[g]),
         .o_rdata  (w_head[g]),
         .o_level  (w_level[g]),
         .o_full   (w_full[g]),
         .o_empty  (w_empty[g])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_valid <= 1'b0;
         r_slot_last  <= 1'b0;
         r_slot_data  <= '0;
         r_slot_ch    <= '0;
         r_last_grant <= '0;
      end else if (w_load) begin
         r_slot_valid <= 1'b1;
         r_slot_last  <= w_load_last;
         r_slot_data  <= w_head[w_pick_ch];
         r_slot_ch    <= w_pick_ch;
         r_last_grant <= w_pick_ch;
      end else if (w_accept) begin
         r_slot_valid <= 1'b0;
         r_slot_last  <= 1'b0;
      end
   end

   always_comb begin
      w_status = '0;
      w_status[ST_RES_VALID] = r_res_valid;
      w_status[ST_OVERFLOW]  = r_overflow;
      w_status[ST_DONE]      = r_done;
      w_status[ST_ALL_EMPTY] = w_all_empty;
      w_status[ST_ANY_FULL]  = w_any_full;
      w_status[15:8]         = sat_level(w_total_level);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmd       <= '0;
         r_thresh    <= '0;
         r_result    <= '0;
         r_rdata     <= '0;
         r_res_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         if (w_wr_cmd)         r_cmd          <= reg_wdata;
         else if (w_done_set)  r_cmd[CMD_EOR] <= 1'b0;

         if (w_wr_thresh) r_thresh <= reg_wdata;
         if (res_valid)   r_result <= res_data;

         // A capture in the same cycle as the RESULT read keeps the flag raised.
         if (res_valid)                       r_res_valid <= 1'b1;
         else if (w_arm_edge || w_rd_result)  r_res_valid <= 1'b0;

         if (w_arm_edge)                              r_overflow <= 1'b0;
         else if (w_drop)                             r_overflow <= 1'b1;
         else if (w_wr_status && reg_wdata[ST_OVERFLOW]) r_overflow <= 1'b0;

         if (w_arm_edge)                          r_done <= 1'b0;
         else if (w_done_set)                     r_done <= 1'b1;
         else if (w_wr_status && reg_wdata[ST_DONE]) r_done <= 1'b0;

         if (reg_re) begin
            case (reg_addr)
               ADDR_CMD:    r_rdata <= r_cmd;
               ADDR_STATUS: r_rdata <= w_status;
               ADDR_RESULT: r_rdata <= r_result;
               ADDR_THRESH: r_rdata <= r_thresh;
               default:     r_rdata <= '0;
            endcase
         end
      end
   end

   assign reg_rdata = r_rdata;
   assign smp_valid = r_slot_valid;
   assign smp_data  = r_slot_data;
   assign smp_ch    = r_slot_ch;
   assign smp_last  = r_slot_last;
   assign irq       = r_res_valid ||
                      (r_cmd[CMD_RUN] && !r_cmd[CMD_EOR] && (w_total_level < r_thresh));

endmodule

// File: tb/tb_caeco_stream_feeder.sv
// Scoreboard bench for caeco_stream_feeder: a 32-bit instance for the main flow and a
// 16-bit instance for PACK mode; monitors pop expected samples as the DUTs deliver them.
module tb_caeco_stream_feeder;

   typedef struct {
      logic [31:0] data;
      logic        ch;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  reg_addr = '0;
   logic        reg_we = 1'b0, reg_re = 1'b0;
   logic [31:0] reg_wdata = '0;
   logic [31:0] reg_rdata;
   logic        smp_valid, smp_last, smp_ready = 1'b1;
   logic [31:0] smp_data;
   logic [0:0]  smp_ch;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = '0;
   logic        irq;

   logic        b_reg_we = 1'b0, b_reg_re = 1'b0;
   logic [31:0] b_reg_rdata;
   logic        b_smp_valid, b_smp_last, b_irq;
   logic        b_smp_ready = 1'b1;
   logic [15:0] b_smp_data;
   logic [0:0]  b_smp_ch;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q[$];
   exp_t q16[$];
   exp_t e_main, e_b;
   logic        r_hold = 1'b0;
   logic [31:0] r_hold_data;
   logic        r_hold_ch;
   logic [31:0] rd;

   always #5 clk = ~clk;

   caeco_stream_feeder #(.NUM_CH(2), .SAMPLE_W(32), .DEPTH(16)) dut (
      .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_we(reg_we), .reg_re(reg_re),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .smp_valid(smp_valid),
      .smp_ready(smp_ready), .smp_data(smp_data), .smp_ch(smp_ch), .smp_last(smp_last),
      .res_valid(res_valid), .res_data(res_data), .irq(irq)
   );

   caeco_stream_feeder #(.NUM_CH(2), .SAMPLE_W(16), .DEPTH(16)) dut16 (
      .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_we(b_reg_we), .reg_re(b_reg_re),
      .reg_wdata(reg_wdata), .reg_rdata(b_reg_rdata), .smp_valid(b_smp_valid),
      .smp_ready(b_smp_ready), .smp_data(b_smp_data), .smp_ch(b_smp_ch), .smp_last(b_smp_last),
      .res_valid(1'b0), .res_data(32'd0), .irq(b_irq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input bit sel, input logic [3:0] addr, input logic [31:0] data);
      @(posedge clk); #2;
      reg_addr = addr; reg_wdata = data;
      if (sel) b_reg_we = 1'b1; else reg_we = 1'b1;
      @(posedge clk); #2;
      reg_we = 1'b0; b_reg_we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
      @(posedge clk); #2;
      reg_addr = addr; reg_re = 1'b1;
      @(posedge clk); #2;
      reg_re = 1'b0;
      data = reg_rdata;
   endtask

   task automatic expect_smp(input logic [31:0] d, input logic c, input logic l);
      q.push_back('{data: d, ch: c, last: l});
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((q.size() != 0 || q16.size() != 0 || smp_valid) && cyc < 200) begin
         @(posedge clk); cyc++;
      end
      repeat (2) @(posedge clk);
      #2;
      check({name, "_drained"}, 32'(q.size() + q16.size()), 32'd0);
   endtask

   // Main scoreboard monitor plus hold-stability check while stalled.
   always @(negedge clk) begin
      if (reset) begin
         r_hold <= 1'b0;
      end else begin
         if (r_hold) begin
            check("hold_data", smp_data, r_hold_data);
            check("hold_ch", 32'(smp_ch), 32'(r_hold_ch));
         end
         if (smp_valid && smp_ready) begin
            if (q.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_sample: got 0x%08h, expected none", smp_data);
            end else begin
               e_main = q.pop_front();
               check("smp_data", smp_data, e_main.data);
               check("smp_ch", 32'(smp_ch), 32'(e_main.ch));
               check("smp_last", 32'(smp_last), 32'(e_main.last));
            end
         end
         r_hold      <= smp_valid && !smp_ready;
         r_hold_data <= smp_data;
         r_hold_ch   <= smp_ch[0];
      end
   end

   always @(negedge clk) begin
      if (!reset && b_smp_valid && b_smp_ready) begin
         if (q16.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_pack_sample: got 0x%04h, expected none", b_smp_data);
         end else begin
            e_b = q16.pop_front();
            check("pack_data", 32'(b_smp_data), e_b.data);
            check("pack_last", 32'(b_smp_last), 32'(e_b.last));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdata", reg_rdata, 32'h0);
      check("rst_valid", 32'(smp_valid), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      @(posedge clk); #2;
      reset = 1'b0;
      bus_read(4'd1, rd); check("rst_status", rd, 32'h0000_0008);
      bus_read(4'd0, rd); check("rst_cmd", rd, 32'h0);

      // Interleaved channels, round-robin order
      bus_write(0, 4'd0, 32'h10);
      bus_write(0, 4'd0, 32'h11);
      expect_smp(32'h1111_1111, 1'b0, 1'b0);
      expect_smp(32'h2222_2222, 1'b1, 1'b0);
      expect_smp(32'h3333_3333, 1'b0, 1'b0);
      bus_write(0, 4'd4, 32'h1111_1111);
      bus_write(0, 4'd5, 32'h2222_2222);
      bus_write(0, 4'd4, 32'h3333_3333);
      wait_drain("rr");

      // PACK mode on the 16-bit instance
      q16.push_back('{data: 32'h1234, ch: 1'b0, last: 1'b0});
      q16.push_back('{data: 32'hABCD, ch: 1'b0, last: 1'b0});
      bus_write(1, 4'd0, 32'h10);
      bus_write(1, 4'd0, 32'h13);
      bus_write(1, 4'd4, 32'h1234_ABCD);
      wait_drain("pack");

      // Overflow on a full channel with RUN off
      bus_write(0, 4'd0, 32'h10);
      for (int i = 0; i < 17; i++) bus_write(0, 4'd4, 32'h1000 + 32'(i));
      for (int i = 0; i < 16; i++) expect_smp(32'h1000 + 32'(i), 1'b0, 1'b0);
      bus_read(4'd1, rd); check("ovf_status", rd, 32'h0000_1012);
      bus_write(0, 4'd1, 32'h2);
      bus_read(4'd1, rd); check("ovf_w1c", rd, 32'h0000_1010);

      // Backpressure: stall with a loaded slot, then release
      smp_ready = 1'b0;
      bus_write(0, 4'd0, 32'h11);
      repeat (6) @(posedge clk);
      #2;
      check("stall_valid", 32'(smp_valid), 32'h1);
      smp_ready = 1'b1;
      wait_drain("stall");

      // End of record with 3 queued samples
      bus_write(0, 4'd0, 32'h10);
      expect_smp(32'h5000, 1'b0, 1'b0);
      expect_smp(32'h5001, 1'b0, 1'b0);
      expect_smp(32'h5002, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) bus_write(0, 4'd4, 32'h5000 + 32'(i));
      bus_write(0, 4'd0, 32'h18);
      bus_write(0, 4'd0, 32'h19);
      wait_drain("eor");
      bus_read(4'd0, rd); check("eor_cmd", rd, 32'h11);
      bus_read(4'd1, rd); check("eor_status", rd, 32'h0000_000C);

      // EOR while idle, ARM re-edge, out-of-range DATA offset
      bus_write(0, 4'd1, 32'h4);
      bus_read(4'd1, rd); check("done_w1c", rd, 32'h0000_0008);
      bus_write(0, 4'd0, 32'h18);
      bus_read(4'd0, rd); check("idle_eor_cmd", rd, 32'h10);
      bus_read(4'd1, rd); check("idle_eor_status", rd, 32'h0000_000C);
      bus_write(0, 4'd0, 32'h00);
      bus_write(0, 4'd0, 32'h10);
      bus_write(0, 4'd6, 32'hDEAD_BEEF);
      bus_read(4'd1, rd); check("arm_clear_status", rd, 32'h0000_0008);

      // Level-below-threshold irq
      bus_write(0, 4'd3, 32'h2);
      bus_write(0, 4'd0, 32'h11);
      check("thresh_irq", 32'(irq), 32'h1);
      bus_read(4'd3, rd); check("thresh_rd", rd, 32'h2);
      bus_write(0, 4'd3, 32'h0);
      check("thresh_irq_off", 32'(irq), 32'h0);

      // Result capture and read-clear, including the same-cycle race
      @(posedge clk); #2;
      res_valid = 1'b1; res_data = 32'hCAFE_0001;
      @(posedge clk); #2;
      res_valid = 1'b0;
      check("res_irq", 32'(irq), 32'h1);
      bus_read(4'd2, rd); check("res_read", rd, 32'hCAFE_0001);
      check("res_irq_clr", 32'(irq), 32'h0);
      @(posedge clk); #2;
      res_valid = 1'b1; res_data = 32'h1234_5678;
      reg_addr = 4'd2; reg_re = 1'b1;
      @(posedge clk); #2;
      res_valid = 1'b0; reg_re = 1'b0;
      check("race_read", reg_rdata, 32'hCAFE_0001);
      check("race_irq", 32'(irq), 32'h1);
      bus_read(4'd2, rd); check("race_new", rd, 32'h1234_5678);
      check("race_irq_clr", 32'(irq), 32'h0);

      // Reset mid-stream
      smp_ready = 1'b0;
      bus_write(0, 4'd4, 32'h7777);
      @(posedge clk); #2;
      res_valid = 1'b1; res_data = 32'h1;
      @(posedge clk); #2;
      res_valid = 1'b0;
      check("pre_rst_valid", 32'(smp_valid), 32'h1);
      bus_read(4'd1, rd); check("pre_rst_status", rd, 32'h0000_0009);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(smp_valid), 32'h0);
      check("mid_rst_data", smp_data, 32'h0);
      check("mid_rst_last", 32'(smp_last), 32'h0);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_rdata", reg_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      smp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      check("final_queue", 32'(q.size() + q16.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
